// File: rtl/serial_add_arbiter_pkg.sv
// Shared definitions for the bit-serial adder arbiter: FSM state encoding,
// default operand width and the round-robin winner selection.
package serial_add_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // On a tie the requester that was not served last wins.
  function automatic logic pick_winner(input logic [1:0] req, input logic last_served);
    logic win;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_served;
      default: win = 1'b0;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single combinational full-adder cell shared by both requesters.
module serial_fa_cell (
  input  logic Cin,
  input  logic x,
  input  logic y,
  output logic s,
  output logic Cout
);

  assign s    = x ^ y ^ Cin;
  assign Cout = (x & y) | (x & Cin) | (y & Cin);

endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter feeding one shared full-adder cell, LSB-first bit-serial add.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_arbiter
  import serial_add_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       cin,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_s, cell_cout;

  serial_fa_cell u_cell (
    .Cin  (carry_q),
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .s    (cell_s),
    .Cout (cell_cout)
  );

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      s_sr_q    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      s_sr_q    <= s_sr_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      win_q     <= win_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Next-state, arbitration and shift datapath.
  always_comb begin
    state_d   = state_q;
    gnt_d     = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    s_sr_d    = s_sr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win_d     = win_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          // Grant is registered so it appears in the LOAD cycle.
          win_d   = pick_winner(req, last_q);
          gnt_d   = win_d ? 2'b10 : 2'b01;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        a_sr_d  = win_q ? a1 : a0;
        b_sr_d  = win_q ? b1 : b0;
        carry_d = cin[win_q];
        cnt_d   = CW'(WIDTH - 1);
        last_d  = win_q;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        s_sr_d  = {cell_s, s_sr_q[WIDTH-1:1]};
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d = cell_cout;
        if (cnt_q == CW'(0)) begin
          // Final bit: publish the result on the edge that enters DONE.
          state_d   = ST_DONE;
          done_d    = 1'b1;
          sum_d     = {cell_s, s_sr_q[WIDTH-1:1]};
          cout_d    = cell_cout;
          done_id_d = win_q;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d     = carry_q ^ cell_cout;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter: directed table, random ops against
// an arithmetic model, continuous-request timing and mid-operation reset.
module tb_serial_add_arbiter;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req, cin;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy, done, done_id, cout;
  logic [W-1:0] sum;
  logic         ovf_s;

  int checks = 0;
  int errors = 0;
  logic model_last;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .cin     (cin),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum     (sum),
    .cout    (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf     (ovf_s)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf_s = 1'b0;
`endif

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   rq;
    logic [W-1:0] xa0, xb0, xa1, xb1;
    logic [1:0]   xcin;
    logic [1:0]   e_gnt;
    logic [W-1:0] e_sum;
    logic         e_cout, e_id, e_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_pick(input logic [1:0] rq);
    if (rq == 2'b01) return 1'b0;
    if (rq == 2'b10) return 1'b1;
    return ~model_last;
  endfunction

  function automatic int as_signed(input logic [W-1:0] v);
    int u;
    u = int'(v);
    return (u >= (1 << (W - 1))) ? u - (1 << W) : u;
  endfunction

  // Starts at an IDLE negedge, ends at the following IDLE negedge.
  task automatic run_op(input vec_t v);
    int lat;
    bit seen;
    req = v.rq; a0 = v.xa0; b0 = v.xb0; a1 = v.xa1; b1 = v.xb1; cin = v.xcin;
    @(negedge clock);
    chk("gnt", 32'(gnt), 32'(v.e_gnt));
    chk("busy_load", 32'(busy), 32'd1);
    model_last = v.e_gnt[1];
    req = 2'b00;
    @(negedge clock);
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    cin = 2'($urandom);
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clock);
        lat++;
      end
    end
    chk("latency", 32'(lat), 32'(W + 1));
    chk("sum", 32'(sum), 32'(v.e_sum));
    chk("cout", 32'(cout), 32'(v.e_cout));
    chk("done_id", 32'(done_id), 32'(v.e_id));
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", 32'(ovf_s), 32'(v.e_ovf));
`endif
    @(negedge clock);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    int next_done, n_done, n_busy_low, n_gnt, next_gnt;
    logic [1:0] exp_g;
    logic w;
    logic [W:0] full;
    int s;

    tbl[0] = '{2'b01, 4'h7, 4'h5, 4'h0, 4'h0, 2'b00, 2'b01, 4'hC, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{2'b11, 4'h3, 4'h4, 4'h9, 4'h9, 2'b11, 2'b10, 4'h3, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{2'b11, 4'hF, 4'hF, 4'h2, 4'h2, 2'b01, 2'b01, 4'hF, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{2'b10, 4'h1, 4'h1, 4'hF, 4'h0, 2'b10, 2'b10, 4'h0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{2'b11, 4'h8, 4'h8, 4'h1, 4'h1, 2'b00, 2'b01, 4'h0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{2'b11, 4'h0, 4'h0, 4'h6, 4'h5, 2'b00, 2'b10, 4'hB, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{2'b01, 4'h7, 4'h1, 4'h3, 4'h3, 2'b00, 2'b01, 4'h8, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0; cin = 2'b00;
    model_last = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_op(tbl[i]);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rv.rq  = 2'($urandom_range(1, 3));
      rv.xa0 = W'($urandom); rv.xb0 = W'($urandom);
      rv.xa1 = W'($urandom); rv.xb1 = W'($urandom);
      rv.xcin = 2'($urandom);
      w = model_pick(rv.rq);
      rv.e_gnt = w ? 2'b10 : 2'b01;
      full = (W+1)'(w ? rv.xa1 : rv.xa0) + (W+1)'(w ? rv.xb1 : rv.xb0)
           + (W+1)'(w ? rv.xcin[1] : rv.xcin[0]);
      rv.e_sum  = full[W-1:0];
      rv.e_cout = full[W];
      rv.e_id   = w;
      s = as_signed(w ? rv.xa1 : rv.xa0) + as_signed(w ? rv.xb1 : rv.xb0)
        + int'(w ? rv.xcin[1] : rv.xcin[0]);
      rv.e_ovf = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      run_op(rv);
    end

    // Requester 0 holds req continuously.
    req = 2'b01; a0 = 4'h3; b0 = 4'h2; cin = 2'b00;
    next_done = W + 2; n_done = 0; n_busy_low = 0;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      @(negedge clock);
      if (done) begin
        chk("done_period", 32'(cyc), 32'(next_done));
        next_done += W + 3;
        n_done++;
      end
      if (!busy) n_busy_low++;
      if (cyc >= W + 2) chk("sum_stable", 32'(sum), 32'h5);
      if (cyc == 28) req = 2'b00;
    end
    chk("done_count", 32'(n_done), 32'd4);
    chk("busy_low_count", 32'(n_busy_low), 32'd4);
    model_last = 1'b0;

    // Reset during the second SHIFT cycle discards the operation.
    req = 2'b10; a1 = 4'hF; b1 = 4'hF; cin = 2'b10;
    @(negedge clock);
    chk("pre_rst_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_done_id", 32'(done_id), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_s), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    n_done = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clock);
      if (done) n_done++;
    end
    chk("no_done_after_rst", 32'(n_done), 32'd0);

    // Tie held after reset: grants alternate starting with requester 0.
    req = 2'b11; a0 = 4'h1; b0 = 4'h1; a1 = 4'h2; b1 = 4'h2; cin = 2'b00;
    exp_g = 2'b01; next_gnt = 1; n_gnt = 0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      @(negedge clock);
      if (gnt != 2'b00) begin
        chk("tie_gnt_cycle", 32'(cyc), 32'(next_gnt));
        chk("tie_gnt", 32'(gnt), 32'(exp_g));
        exp_g = ~exp_g;
        next_gnt += W + 3;
        n_gnt++;
      end
    end
    chk("tie_gnt_count", 32'(n_gnt), 32'd4);
    req = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
